// File: rtl/instr_mem_sync.sv
// Synchronous instruction memory: boot-loaded word store with a one-cycle registered fetch port.
// Define IMEM_PARITY_EN to keep an even-parity bit per word and flag read mismatches on parity_err.
module instr_mem_sync #(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 16,
  parameter int PC_W       = 16,
  parameter int BYTE_SHIFT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [DATA_W-1:0]        load_data,
  input  logic                     load_done,
  input  logic                     fetch_req,
  input  logic [PC_W-1:0]          pc,
  output logic                     fetch_ready,
  input  logic                     flush,
  input  logic                     stall,
  output logic [DATA_W-1:0]        instr,
  output logic                     instr_valid,
  output logic                     addr_err,
  output logic                     misalign_err,
  output logic                     parity_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [PC_W-1:0] LOW_MASK = PC_W'((64'(1) << BYTE_SHIFT) - 64'(1));

  typedef enum logic {BOOT, RUN} state_t;

  state_t state;
  state_t state_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;
  logic              rd_par_bad;
  logic              pc_hi_nz;
  logic              pc_misalign;
  logic              load_we;
  logic              fetch_acc;
  logic              hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_next;
  end

  // Boot is one-way; only reset brings the machine back to BOOT.
  always_comb begin
    state_next = state;
    if (state == BOOT && load_done) state_next = RUN;
  end

  assign load_ready  = (state == BOOT);
  assign fetch_ready = (state == RUN) && !flush && !(instr_valid && stall);
  assign load_we     = load_valid && load_ready;
  assign fetch_acc   = fetch_req && fetch_ready;
  assign hold        = instr_valid && stall && !flush;

  assign idx         = pc[BYTE_SHIFT +: IDX_W];
  assign pc_hi_nz    = (pc >> (BYTE_SHIFT + IDX_W)) != '0;
  assign pc_misalign = (pc & LOW_MASK) != '0;
  assign rd_word     = mem[idx];

  // Memory contents are intentionally outside the reset domain.
  always_ff @(posedge clk) begin
    if (load_we) mem[load_addr] <= load_data;
  end

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (load_we) par_mem[load_addr] <= ^load_data;
  end

  assign rd_par_bad = (^rd_word) != par_mem[idx];
`else
  assign rd_par_bad = 1'b0;
`endif

  // Output stage: load on accept, freeze under stall, otherwise fall back to an empty slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr        <= '0;
      instr_valid  <= 1'b0;
      addr_err     <= 1'b0;
      misalign_err <= 1'b0;
      parity_err   <= 1'b0;
    end else if (fetch_acc) begin
      instr        <= pc_hi_nz ? '0 : rd_word;
      instr_valid  <= 1'b1;
      addr_err     <= pc_hi_nz;
      misalign_err <= pc_misalign;
      parity_err   <= !pc_hi_nz && rd_par_bad;
    end else if (!hold) begin
      instr        <= '0;
      instr_valid  <= 1'b0;
      addr_err     <= 1'b0;
      misalign_err <= 1'b0;
      parity_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Scoreboard bench for instr_mem_sync: stimulus pushes expected fetch results, a negedge monitor pops and compares.
// With IMEM_PARITY_EN defined it also corrupts one stored word and expects parity_err.
module tb_instr_mem_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [3:0]  load_addr;
  logic [15:0] load_data;
  logic        load_done;
  logic        fetch_req;
  logic [15:0] pc;
  logic        fetch_ready;
  logic        flush;
  logic        stall;
  logic [15:0] instr;
  logic        instr_valid;
  logic        addr_err;
  logic        misalign_err;
  logic        parity_err;

  typedef struct packed {
    logic [15:0] instr;
    logic        addr_err;
    logic        misalign_err;
    logic        parity_err;
  } resp_t;

  resp_t       exp_q[$];
  resp_t       mon_exp;
  logic [15:0] ref_mem [16];
  logic        ref_bad [16];
  bit          running;
  int          tests;
  int          fails;

  instr_mem_sync #(
    .DATA_W(16), .DEPTH(16), .PC_W(16), .BYTE_SHIFT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
    .load_data(load_data), .load_done(load_done),
    .fetch_req(fetch_req), .pc(pc), .fetch_ready(fetch_ready),
    .flush(flush), .stall(stall),
    .instr(instr), .instr_valid(instr_valid),
    .addr_err(addr_err), .misalign_err(misalign_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Byte address -> word: 2-byte words, 16 of them, anything at or above 32 is out of range.
  function automatic resp_t refModel(input logic [15:0] p);
    resp_t r;
    int    word_addr;
    r         = '0;
    word_addr = int'(p) / 2;
    r.misalign_err = (int'(p) % 2) != 0;
    if (word_addr >= 16) begin
      r.addr_err = 1'b1;
    end else begin
      r.instr = ref_mem[word_addr];
`ifdef IMEM_PARITY_EN
      r.parity_err = ref_bad[word_addr];
`endif
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic applyStimulus(input logic req, input logic [15:0] p, input logic st, input logic fl);
    logic exp_ready;
    exp_ready = running && !fl && !(exp_q.size() != 0 && st);
    fetch_req = req;
    pc        = p;
    stall     = st;
    flush     = fl;
    #1 checkOutput("fetch_ready", 32'(fetch_ready), 32'(exp_ready));
    @(posedge clk);
    if (req && exp_ready) exp_q.push_back(refModel(p));
    #1;
  endtask

  task automatic loadWord(input logic [3:0] a, input logic [15:0] d, input logic done);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    load_done  = done;
    #1 checkOutput("load_ready", 32'(load_ready), 32'd1);
    @(posedge clk);
    ref_mem[a] = d;
    ref_bad[a] = 1'b0;
    if (done) running = 1'b1;
    #1;
    load_valid = 1'b0;
    load_done  = 1'b0;
  endtask

  task automatic pulseLoadDone();
    load_done = 1'b1;
    @(posedge clk);
    running = 1'b1;
    #1 load_done = 1'b0;
  endtask

  // Monitor: the head of the queue is what the DUT should be presenting; it retires when consumed or flushed.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (instr_valid) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_valid: got instr 0x%0h with nothing outstanding at %0t", instr, $time);
          end else begin
            mon_exp = exp_q[0];
            checkOutput("instr", 32'(instr), 32'(mon_exp.instr));
            checkOutput("addr_err", 32'(addr_err), 32'(mon_exp.addr_err));
            checkOutput("misalign_err", 32'(misalign_err), 32'(mon_exp.misalign_err));
            checkOutput("parity_err", 32'(parity_err), 32'(mon_exp.parity_err));
            if (!stall || flush) void'(exp_q.pop_front());
          end
        end else begin
          checkOutput("idle_flags", 32'({addr_err, misalign_err, parity_err}), 32'd0);
          checkOutput("lost_result", 32'(exp_q.size()), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] rp;
    int          sel;
    tests = 0;
    fails = 0;
    running = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = '0;
      ref_bad[i] = 1'b0;
    end
    rst_n = 1'b0;
    load_valid = 1'b0; load_addr = '0; load_data = '0; load_done = 1'b0;
    fetch_req = 1'b0; pc = '0; flush = 1'b0; stall = 1'b0;
    #1;
    checkOutput("reset_valid", 32'(instr_valid), 32'd0);
    checkOutput("reset_instr", 32'(instr), 32'd0);
    checkOutput("reset_load_ready", 32'(load_ready), 32'd1);
    checkOutput("reset_fetch_ready", 32'(fetch_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Boot load; the last write coincides with load_done.
    for (int i = 0; i < 16; i++) loadWord(4'(i), 16'hA000 + 16'(i), i == 15);
    checkOutput("run_load_ready", 32'(load_ready), 32'd0);

    applyStimulus(1'b1, 16'h0006, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

    // Back-to-back with the second result stalled for two cycles.
    applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0002, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0004, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0004, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0004, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

    applyStimulus(1'b1, 16'h0021, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0003, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

    // Flush beats stall on a valid output.
    applyStimulus(1'b1, 16'h0008, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h000A, 1'b1, 1'b1);
    checkOutput("flush_clears_valid", 32'(instr_valid), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

    // Asynchronous reset with a result on the output.
    applyStimulus(1'b1, 16'h0006, 1'b0, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    running = 1'b0;
    #1;
    checkOutput("midreset_valid", 32'(instr_valid), 32'd0);
    checkOutput("midreset_instr", 32'(instr), 32'd0);
    checkOutput("midreset_flags", 32'({addr_err, misalign_err, parity_err}), 32'd0);
    checkOutput("midreset_fetch_ready", 32'(fetch_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h0006, 1'b0, 1'b0);
    pulseLoadDone();
    applyStimulus(1'b1, 16'h0006, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

`ifdef IMEM_PARITY_EN
    dut.mem[5] = dut.mem[5] ^ 16'h0100;
    ref_mem[5] = ref_mem[5] ^ 16'h0100;
    ref_bad[5] = 1'b1;
    applyStimulus(1'b1, 16'h000A, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
`endif

    // Random traffic: mostly in-range aligned fetches, some odd and out-of-range addresses.
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      rp = 16'($urandom);
      else if (sel == 1) rp = 16'($urandom_range(0, 31)) | 16'h0001;
      else               rp = 16'($urandom_range(0, 15)) << 1;
      applyStimulus($urandom_range(0, 3) != 0, rp,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_mem_sync.md
INSTR_MEM_SYNC -- requirements
Module: instr_mem_sync

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning number of instruction words; power of two, 2..1024.
REQ-003 SHALL have parameter PC_W, default 16, meaning program-counter width.
REQ-004 SHALL have parameter BYTE_SHIFT, default 1, meaning pc-to-word-index right shift; word index = pc[BYTE_SHIFT +: log2(DEPTH)].
REQ-005 SHALL have port clk, input, 1, meaning single rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port load_valid, input, 1, meaning boot-load write request.
REQ-008 SHALL have port load_ready, output, 1, meaning boot-load write accepted this cycle if load_valid.
REQ-009 SHALL have port load_addr, input, log2(DEPTH), meaning word index to write.
REQ-010 SHALL have port load_data, input, DATA_W, meaning word to write.
REQ-011 SHALL have port load_done, input, 1, meaning single-cycle pulse that ends boot load.
REQ-012 SHALL have port fetch_req, input, 1, meaning fetch request.
REQ-013 SHALL have port pc, input, PC_W, meaning fetch byte address.
REQ-014 SHALL have port fetch_ready, output, 1, meaning fetch accepted this cycle if fetch_req.
REQ-015 SHALL have port flush, input, 1, meaning discard pending output (branch taken).
REQ-016 SHALL have port stall, input, 1, meaning consumer not taking instr this cycle.
REQ-017 SHALL have port instr, output, DATA_W, meaning fetched instruction.
REQ-018 SHALL have port instr_valid, output, 1, meaning instr holds a valid fetch result.
REQ-019 SHALL have ports addr_err, misalign_err and parity_err, each output, 1, meaning per-fetch error flags qualified by instr_valid.

Function
REQ-020 SHALL implement a state machine with states BOOT and RUN: BOOT -> RUN on load_done, and RUN -> RUN otherwise; there SHALL be no return to BOOT except via reset.
REQ-021 SHALL drive load_ready = (state==BOOT) and write load_data to load_addr on clk when load_valid && load_ready.
REQ-022 SHALL, when load_valid and load_done coincide, complete the write and then enter RUN.
REQ-023 SHALL drive fetch_ready = (state==RUN) && !flush && !(instr_valid && stall).
REQ-024 SHALL present instr and instr_valid=1 exactly one clock after an accepted fetch (registered read, latency 1), supporting back-to-back fetches at one per cycle.
REQ-025 SHALL hold instr, instr_valid and the error flags unchanged while instr_valid && stall && !flush.
REQ-026 SHALL clear instr_valid on the clock after no fetch is accepted, unless a stall is holding the output.
REQ-027 SHALL, on flush, give flush priority: no fetch is accepted that cycle, and instr_valid=0 on the next cycle, even under stall.
REQ-028 SHALL, when the pc bits above the index field are nonzero, output instr=0 (NOP) with addr_err=1.
REQ-029 SHALL, when BYTE_SHIFT>0 and pc[BYTE_SHIFT-1:0] is nonzero, set misalign_err=1 and still return the word at the truncated index.
REQ-030 SHALL keep all error flags 0 whenever instr_valid=0.

Reset
REQ-031 SHALL, on rst_n low, immediately force state=BOOT and instr=0, instr_valid=0, addr_err=0, misalign_err=0, parity_err=0; consequently load_ready=1 and fetch_ready=0.
REQ-032 SHALL NOT reset or clear memory contents; reset mid-run SHALL retain loaded words, but a new load_done is still required to re-enter RUN.
REQ-033 SHALL treat a fetch in flight at reset assertion as discarded, with no valid output after reset release.

Configuration
REQ-034 SHALL, with IMEM_PARITY_EN defined, store one even-parity bit per word on load, recompute it on read, and set parity_err=1 with instr_valid on mismatch.
REQ-035 SHALL, without IMEM_PARITY_EN, have no parity storage and tie parity_err to 0.

Verification
REQ-036 Bench SHALL cover: load words 0..15 with 16'hA000+i, pulse load_done, fetch pc=0x0006 -> next cycle instr=16'hA003, instr_valid=1, all error flags 0.
REQ-037 Bench SHALL cover: back-to-back fetch pc=0,2,4 with stall=1 on the second result -> instr holds 16'hA001 for the stall cycles, fetch_ready=0, and the sequence resumes with no loss or duplication.
REQ-038 Bench SHALL cover: fetch pc=0x0021 -> addr_err=1 and instr=0; fetch pc=0x0003 -> misalign_err=1 and instr=16'hA001.
REQ-039 Bench SHALL cover: flush asserted together with stall and a valid output -> fetch_ready=0, and instr_valid=0 on the next cycle.
REQ-040 Bench SHALL cover: rst_n pulsed low mid-run -> outputs zero asynchronously and fetch_ready=0 until load_done; after load_done, fetch pc=0x0006 still returns 16'hA003.
REQ-041 Bench SHALL cover, with IMEM_PARITY_EN defined: force-flip one stored data bit -> fetch of that word gives parity_err=1; without the macro, parity_err stays 0.
